// File: rtl/mby_msh_pkg.sv
// Shared mesh-node types: link directions, eject arbitration result and the
// round-robin winner search used by every plane's eject arbiter.
package mby_msh_pkg;

   localparam int NUM_MSH_DIRS = 4;

   typedef enum logic [1:0] {
      MSH_NB = 2'd0,
      MSH_SB = 2'd1,
      MSH_EB = 2'd2,
      MSH_WB = 2'd3
   } msh_dir_e;

   typedef struct packed {
      logic     vld;
      msh_dir_e dir;
   } msh_ej_entry_t;

   // First non-empty direction at or after rr, wrapping modulo 4.
   function automatic msh_ej_entry_t msh_pick_winner(input logic [NUM_MSH_DIRS-1:0] nonempty,
                                                     input logic [1:0]              rr);
      msh_ej_entry_t e;
      logic [1:0]    idx;
      e.vld = 1'b0;
      e.dir = MSH_NB;
      for (int k = NUM_MSH_DIRS - 1; k >= 0; k--) begin
         idx = rr + 2'(k);
         if (nonempty[idx]) begin
            e.vld = 1'b1;
            e.dir = msh_dir_e'(idx);
         end
      end
      return e;
   endfunction

endpackage

// File: rtl/mby_msh_node_eject_fifo.sv
// Synchronous eject FIFO; a push into a full FIFO is accepted when the same
// cycle also pops. No read bypass: a pushed entry is visible the next cycle.
module mby_msh_ej_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_cnt == FULL_CNT);
   assign o_empty   = (r_cnt == '0);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_data    = r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/mby_msh_node_eject.sv
// Mesh node stage: forwards chunks for other nodes through one register,
// ejects chunks for this node into per-direction FIFOs drained round-robin.
module mby_msh_node_eject
   import mby_msh_pkg::*;
#(
   parameter int NUM_PLANES = 4,
   parameter int DATA_W     = 512,
   parameter int ROW_W      = 4,
   parameter int COL_W      = 4,
   parameter int EJ_DEPTH   = 4,
   parameter int CNT_W      = 16
) (
   input  logic                                  mclk,
   input  logic                                  i_reset,
   input  logic [ROW_W-1:0]                      i_node_row,
   input  logic [COL_W-1:0]                      i_node_col,
   input  logic [NUM_MSH_DIRS*NUM_PLANES-1:0]        i_vld,
   input  logic [NUM_MSH_DIRS*NUM_PLANES*ROW_W-1:0]  i_dst_row,
   input  logic [NUM_MSH_DIRS*NUM_PLANES*COL_W-1:0]  i_dst_col,
   input  logic [NUM_MSH_DIRS*NUM_PLANES*DATA_W-1:0] i_data,
   output logic [NUM_MSH_DIRS*NUM_PLANES-1:0]        o_vld,
   output logic [NUM_MSH_DIRS*NUM_PLANES*ROW_W-1:0]  o_dst_row,
   output logic [NUM_MSH_DIRS*NUM_PLANES*COL_W-1:0]  o_dst_col,
   output logic [NUM_MSH_DIRS*NUM_PLANES*DATA_W-1:0] o_data,
   output logic [NUM_PLANES-1:0]                 o_ej_vld,
   output logic [2*NUM_PLANES-1:0]               o_ej_dir,
   output logic [NUM_PLANES*DATA_W-1:0]          o_ej_data,
   input  logic [NUM_PLANES-1:0]                 i_ej_rdy,
   output logic [NUM_PLANES-1:0]                 o_ovf,
   output logic [NUM_PLANES*CNT_W-1:0]           o_drop_cnt
);

   localparam int NS = NUM_MSH_DIRS * NUM_PLANES;

   logic [NS-1:0] w_match;
   logic [NS-1:0] w_fwd;
   logic [NS-1:0] w_full;
   logic [NS-1:0] w_empty;
   logic [NS-1:0] w_pop;
   logic [NS-1:0] w_drop;

   logic [NS-1:0]        r_fwd_vld_p1;
   logic [NS*ROW_W-1:0]  r_fwd_row_p1;
   logic [NS*COL_W-1:0]  r_fwd_col_p1;
   logic [NS*DATA_W-1:0] r_fwd_data_p1;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
      logic [CNT_W+2:0] sum;
      sum = {3'b000, a} + {{CNT_W{1'b0}}, b};
      if (|sum[CNT_W+2:CNT_W]) return '1;
      return sum[CNT_W-1:0];
   endfunction

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   for (genvar s = 0; s < NS; s++) begin : g_slot
      assign w_match[s] = i_vld[s] & (i_dst_row[s*ROW_W +: ROW_W] == i_node_row)
                                   & (i_dst_col[s*COL_W +: COL_W] == i_node_col);
      assign w_fwd[s]   = i_vld[s] & ~w_match[s];
   end

   // p0 -> p1: forward register; fields of idle slots hold their last value
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         r_fwd_vld_p1  <= '0;
         r_fwd_row_p1  <= '0;
         r_fwd_col_p1  <= '0;
         r_fwd_data_p1 <= '0;
      end else begin
         r_fwd_vld_p1 <= w_fwd;
         for (int s = 0; s < NS; s++) begin
            if (w_fwd[s]) begin
               r_fwd_row_p1[s*ROW_W +: ROW_W]    <= i_dst_row[s*ROW_W +: ROW_W];
               r_fwd_col_p1[s*COL_W +: COL_W]    <= i_dst_col[s*COL_W +: COL_W];
               r_fwd_data_p1[s*DATA_W +: DATA_W] <= i_data[s*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign o_vld     = r_fwd_vld_p1;
   assign o_dst_row = r_fwd_row_p1;
   assign o_dst_col = r_fwd_col_p1;
   assign o_data    = r_fwd_data_p1;

   for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
      logic [DATA_W-1:0] w_head [NUM_MSH_DIRS];
      logic [1:0]        r_rr;
      logic              r_ovf;
      logic [CNT_W-1:0]  r_drop_cnt;
      msh_ej_entry_t     w_win;
      logic              w_pop_any;

      for (genvar d = 0; d < NUM_MSH_DIRS; d++) begin : g_dir
         localparam int S = p * NUM_MSH_DIRS + d;

         mby_msh_ej_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (EJ_DEPTH)
         ) u_fifo (
            .i_clk   (mclk),
            .i_reset (i_reset),
            .i_push  (w_match[S]),
            .i_pop   (w_pop[S]),
            .i_data  (i_data[S*DATA_W +: DATA_W]),
            .o_data  (w_head[d]),
            .o_full  (w_full[S]),
            .o_empty (w_empty[S])
         );

         assign w_pop[S]  = w_pop_any & (w_win.dir == msh_dir_e'(2'(d)));
         assign w_drop[S] = w_match[S] & w_full[S] & ~w_pop[S];
      end

      assign w_win     = msh_pick_winner(~w_empty[p*NUM_MSH_DIRS +: NUM_MSH_DIRS], r_rr);
      assign w_pop_any = w_win.vld & i_ej_rdy[p];

      always_ff @(posedge mclk) begin
         if (i_reset) begin
            r_rr       <= MSH_NB;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
         end else begin
            if (w_pop_any) r_rr <= w_win.dir + 2'd1;
            if (|w_drop[p*NUM_MSH_DIRS +: NUM_MSH_DIRS]) begin
               r_ovf      <= 1'b1;
               r_drop_cnt <= sat_add(r_drop_cnt, popcnt4(w_drop[p*NUM_MSH_DIRS +: NUM_MSH_DIRS]));
            end
         end
      end

      assign o_ej_vld[p]                   = w_win.vld;
      assign o_ej_dir[p*2 +: 2]            = w_win.dir;
      assign o_ej_data[p*DATA_W +: DATA_W] = w_win.vld ? w_head[w_win.dir] : '0;
      assign o_ovf[p]                      = r_ovf;
      assign o_drop_cnt[p*CNT_W +: CNT_W]  = r_drop_cnt;
   end

endmodule

// File: doc/mby_msh_node_eject.md
# mby_msh_node_eject

Parametrised next-generation mesh-node datapath stage, sitting between the four directional mesh links of a node and its local memory-bank write path. For every plane and direction it does one of two things with each incoming chunk. A chunk addressed to another node is forwarded through a one-cycle register stage. A chunk addressed to this node is ejected into a per-direction FIFO. A per-plane round-robin arbiter then drains the four FIFOs into a ready/valid local eject port. Plane count, data width, coordinate width and FIFO depth are all parameters, and the block counts overflow drops.

## Interface
Parameters:
- NUM_PLANES, 4, number of independent mesh planes
- DATA_W, 512, chunk payload width
- ROW_W, 4, destination row coordinate width
- COL_W, 4, destination column coordinate width
- EJ_DEPTH, 4, entries per eject FIFO (power of two, ≥2)
- CNT_W, 16, drop-counter width

Ports (index p*4+d; d: 0=NB, 1=SB, 2=EB, 3=WB). Fields of slot k occupy bits [k*W +: W].
- mclk  in  1  mesh clock
- i_reset  in  1  reset, synchronous active-high
- i_node_row  in  ROW_W  this node's row, static after reset
- i_node_col  in  COL_W  this node's column, static after reset
- i_vld  in  4*NUM_PLANES  incoming chunk valid
- i_dst_row  in  4*NUM_PLANES*ROW_W  incoming destination row
- i_dst_col  in  4*NUM_PLANES*COL_W  incoming destination column
- i_data  in  4*NUM_PLANES*DATA_W  incoming payload
- o_vld  out  4*NUM_PLANES  forwarded chunk valid, same direction
- o_dst_row  out  4*NUM_PLANES*ROW_W  forwarded destination row
- o_dst_col  out  4*NUM_PLANES*COL_W  forwarded destination column
- o_data  out  4*NUM_PLANES*DATA_W  forwarded payload
- o_ej_vld  out  NUM_PLANES  eject valid
- o_ej_dir  out  2*NUM_PLANES  arrival direction of the ejected chunk
- o_ej_data  out  NUM_PLANES*DATA_W  ejected payload
- i_ej_rdy  in  NUM_PLANES  eject consumer ready
- o_ovf  out  NUM_PLANES  sticky overflow flag
- o_drop_cnt  out  NUM_PLANES*CNT_W  saturating drop count

## Operation
- Match rule: a slot matches when i_vld=1, i_dst_row==i_node_row and i_dst_col==i_node_col.
- Forwarding: a valid, non-matching slot is registered onto the same slot of o_*. When a slot is not forwarded, o_vld=0 and the other o_* fields of that slot hold their previous value.
- Ejection: a matching slot pushes {data} into FIFO[p][d]. A matching chunk is never forwarded.
- Full-FIFO push:
  - If the FIFO is full and pops in the same cycle, the push is accepted.
  - If the FIFO is full and does not pop, the chunk is dropped, o_ovf[p] sets, and o_drop_cnt[p] increments, saturating at 2^CNT_W-1.
  - Multiple drops on the same plane in one cycle increment the count by the number dropped, still saturating.
- Arbiter, one per plane:
  - Pointer rr[p] (2 bits) selects the first non-empty FIFO searching d = rr, rr+1, … modulo 4.
  - o_ej_vld[p] = any FIFO on the plane is non-empty.
  - o_ej_data and o_ej_dir come combinationally from the winner's head.
  - A pop happens when o_ej_vld & i_ej_rdy. On a pop, rr[p] becomes winner+1 mod 4. Otherwise rr[p] holds.
- Eject outputs are stable while o_ej_vld=1 and i_ej_rdy=0, unless a FIFO with higher priority than the current winner becomes non-empty. Consumers must not assume stability beyond the current cycle.
- o_ovf and o_drop_cnt clear only on reset.

## Timing
- Forward latency: exactly 1 cycle, input slot at cycle N appears on output at N+1. Full throughput is one chunk per slot per cycle.
- Eject latency: a push at N is visible on o_ej_vld no earlier than N+1. The FIFO has no bypass.
- Eject throughput: one pop per plane per cycle.
- FIFO pointers wrap modulo EJ_DEPTH. Full/empty are derived from a count of width clog2(EJ_DEPTH)+1.
- Reset values: o_vld=0, o_ej_vld=0, o_ovf=0, o_drop_cnt=0, all FIFOs empty, rr=0 (NB). Data outputs reset to 0.
- Reset asserted mid-operation: every slot's o_vld=0 and o_ej_vld=0 starting the cycle after the sampling edge, and FIFO contents are discarded. Inputs are ignored while i_reset=1.

## Structure
- mby_msh_pkg holds:
  - NUM_MSH_DIRS=4
  - enum msh_dir_e {MSH_NB, MSH_SB, MSH_EB, MSH_WB}
  - typedef msh_ej_entry_t
- Sub-module mby_msh_ej_fifo: a parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty and simultaneous push+pop when full. It is instantiated 4*NUM_PLANES times in generate loops. The arbiter and counters stay inline.

## Test plan
- Node (2,3), NB plane 0 chunk with dst (5,3) and data 0xA5 at cycle 10 -> o_vld[0]=1 with data 0xA5 at cycle 11. No eject.
- All 4 directions on plane 1 target (2,3) in one cycle, i_ej_rdy=1 -> o_ej_dir sequence NB, SB, EB, WB over 4 consecutive cycles. Then rr=NB.
- EJ_DEPTH=4, i_ej_rdy=0, 5 matching EB chunks -> FIFO holds 4, o_ovf[p]=1, o_drop_cnt[p]=1. The first-pushed data pops first.
- Full FIFO with i_ej_rdy=1 and a matching push in the same cycle -> no drop, occupancy stays 4.
- CNT_W=2 with 5 drops -> o_drop_cnt saturates at 3.
- Reset pulse while 3 entries are queued and forwards are in flight -> next cycle all valids=0 and counters=0. A post-reset eject starts from NB.
